instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of instruction_decode.
- Holds the program counter and issues word reads to the instruction memory over a req/ack handshake.
- Registers the returned word and presents it as Instr, stable until the control unit asks for the next PC.
- Computes the next PC as PC+4 or PC+4+Immed, using the Immed and branch select fed back from decode and control.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
MEM_ADDR_W, 10, width of the word address to instruction memory (1024 words).

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
PC_sel  input  1  0: next PC = PC+4; 1: next PC = PC+4+PC_Immed
PC_LdEn  input  1  control pulse: advance PC and start next fetch
PC_Immed  input  32  sign-extended branch offset from decode (byte offset)
Mem_Rdata  input  32  instruction word from memory
Mem_Ack  input  1  memory read complete; Mem_Rdata valid this cycle
Mem_Req  output  1  read request, held until acknowledged
Mem_Addr  output  MEM_ADDR_W  word address = PC[MEM_ADDR_W+1:2]
Instr  output  32  registered instruction to decode
Instr_Valid  output  1  Instr holds the word fetched from current PC
PC  output  32  current program counter
Addr_Err  output  1  sticky: a computed next PC was not word-aligned

Behaviour:
- Reset (Reset=0, asynchronous):
  - PC=PC_RESET, Instr=0, Instr_Valid=0, Mem_Req=0, Addr_Err=0, state=IDLE.
  - Mem_Req drops immediately even mid-fetch; any in-flight ack is discarded.
- FSM states IDLE, REQ, HOLD:
  - IDLE: first edge after Reset rises -> REQ.
  - REQ: Mem_Req=1, Mem_Addr=PC[MEM_ADDR_W+1:2], both stable until ack. On an edge with Mem_Ack=1: Instr<=Mem_Rdata, Instr_Valid<=1, Mem_Req<=0, -> HOLD. Mem_Ack=0: stay.
  - HOLD: Mem_Req=0, Instr stable. On an edge with PC_LdEn=1: PC<=next_PC, Instr_Valid<=0, -> REQ. Otherwise stay.
- Latency:
  - Minimum 2 edges from PC_LdEn sampled in HOLD to Instr_Valid=1: one edge to enter REQ, one edge with Mem_Ack=1.
  - Each wait-state cycle of Mem_Ack=0 adds one cycle.
- Ignored inputs:
  - PC_LdEn in IDLE or REQ is ignored; no PC change, no queuing.
  - Mem_Ack outside REQ is ignored.
- next_PC:
  - PC_sel=0: PC+32'd4.
  - PC_sel=1: PC+32'd4+PC_Immed.
  - All 32-bit arithmetic, modulo 2^32; wrap-around is legal, e.g. 32'hFFFF_FFFC+4 = 0.
- Alignment:
  - If next_PC[1:0]!=0, PC loads next_PC with bits [1:0] forced to 0, and Addr_Err<=1.
  - Addr_Err stays set until reset.
- Mem_Addr truncation: upper PC bits above MEM_ADDR_W+1 are not presented (memory aliasing is legal).
- Simultaneous events:
  - Mem_Ack and PC_LdEn both high in REQ: ack is taken, PC_LdEn ignored.
  - Reset asserted in the same cycle as Mem_Ack: reset wins.
- PC output is the registered PC; it changes only on the HOLD->REQ transition or on reset.

Test Plan:
- Reset release, memory word 0 = 32'hC010_8004, ack on first REQ cycle -> Mem_Addr=0, Instr=32'hC010_8004, Instr_Valid=1 two edges after release, PC=0.
- In HOLD, PC_sel=0, PC_LdEn pulse -> PC=4, Mem_Addr=1, Instr_Valid low for exactly one cycle with a zero-wait ack; word 1 appears on Instr.
- PC=8, PC_sel=1, PC_Immed=32'hFFFF_FFF4 (-12), PC_LdEn -> PC=0, Mem_Addr=0. Then PC_Immed=32'h0000_0010 from PC=0 -> PC=20.
- Mem_Ack delayed 3 cycles -> Mem_Req and Mem_Addr stable for 4 cycles, Instr unchanged until the ack edge, and PC_LdEn pulsed during the wait has no effect.
- PC=32'hFFFF_FFFC, PC_sel=0, PC_LdEn -> PC=0 (wrap). From PC=0 with PC_Immed=32'h0000_0002, PC_sel=1 -> PC=4 and Addr_Err=1, sticky across further fetches.
- Reset asserted during REQ with Mem_Ack arriving the same cycle -> Mem_Req=0 immediately, Instr=0, PC=PC_RESET, ack not captured.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, reads one instruction word per PC over a req/ack
// handshake, and presents the registered word to decode until the next PC load.
module instruction_fetch #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          MEM_ADDR_W = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  PC_sel,
    input  logic                  PC_LdEn,
    input  logic [31:0]           PC_Immed,
    input  logic [31:0]           Mem_Rdata,
    input  logic                  Mem_Ack,
    output logic                  Mem_Req,
    output logic [MEM_ADDR_W-1:0] Mem_Addr,
    output logic [31:0]           Instr,
    output logic                  Instr_Valid,
    output logic [31:0]           PC,
    output logic                  Addr_Err
);

    // state  | meaning
    // IDLE   | out of reset, fetch of PC_RESET not yet started
    // REQ    | Mem_Req high, waiting for Mem_Ack
    // HOLD   | Instr valid for current PC, waiting for PC_LdEn
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] PC_RESET_ALIGNED = {PC_RESET[31:2], 2'b00};

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        mem_req_q;
    logic        addr_err_q;

    logic [31:0] pc_sum;
    logic [31:0] pc_d;
    logic        misalign_d;

    // Misaligned targets are truncated to the word boundary and flagged.
    always_comb begin
        pc_sum     = pc_q + 32'd4 + (PC_sel ? PC_Immed : 32'd0);
        pc_d       = {pc_sum[31:2], 2'b00};
        misalign_d = |pc_sum[1:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            pc_q          <= PC_RESET_ALIGNED;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mem_req_q <= 1'b1;
                    state_q   <= S_REQ;
                end
                S_REQ: begin
                    if (Mem_Ack) begin
                        instr_q       <= Mem_Rdata;
                        instr_valid_q <= 1'b1;
                        mem_req_q     <= 1'b0;
                        state_q       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (PC_LdEn) begin
                        pc_q          <= pc_d;
                        instr_valid_q <= 1'b0;
                        mem_req_q     <= 1'b1;
                        if (misalign_d) begin
                            addr_err_q <= 1'b1;
                        end
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // Upper PC bits are dropped; the memory aliases beyond its word range.
    assign Mem_Addr    = pc_q[MEM_ADDR_W+1:2];
    assign Mem_Req     = mem_req_q;
    assign Instr       = instr_q;
    assign Instr_Valid = instr_valid_q;
    assign PC          = pc_q;
    assign Addr_Err    = addr_err_q;

endmodule
